// File: rtl/pulse_width_decoder_if.sv
// Pulse-width decoder signal bundle: the raw pulse line in, decoded strobes and status out.
interface pulse_width_decoder_if #(
  parameter int CNT_W = 8
);
  logic             in;
  logic             evt;
  logic [CNT_W-1:0] width;
  logic             err_short;
  logic             err_long;
  logic             busy;
  logic [7:0]       event_count;

  modport master (output in, input evt, width, err_short, err_long, busy, event_count);
  modport slave  (input in, output evt, width, err_short, err_long, busy, event_count);
endinterface

// File: rtl/pulse_width_decoder.sv
// Measures high pulses on an asynchronous line; emits a one-cycle event with the width,
// or a short/long error strobe for glitches and overlong pulses.
module pulse_width_decoder #(
  parameter int CNT_W = 8,
  parameter int MIN_W = 2,
  parameter int MAX_W = 200
) (
  input  logic                  clk,
  input  logic                  reset_n,
  pulse_width_decoder_if.slave  pw
);
  typedef enum logic [1:0] {ARM, IDLE, MEASURE, OVERLONG} state_t;

  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_W);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_W);

  state_t           state;
  logic             s1, s2;
  logic [1:0]       prime;
  logic [CNT_W-1:0] cnt;
  logic             evt_q, short_q, long_q;
  logic [CNT_W-1:0] width_q;
  logic [7:0]       ecnt_q;
  logic             in_s;

  assign in_s = s2;

  // prime marks when the sync chain holds a real sample of the line; until then the
  // reset zeros in s2 could make a line held high look low and let ARM release early.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      prime <= 2'b00;
    end else begin
      s1    <= pw.in;
      s2    <= s1;
      prime <= {prime[0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ARM;
      cnt     <= '0;
      evt_q   <= 1'b0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      width_q <= '0;
      ecnt_q  <= '0;
    end else begin
      evt_q   <= 1'b0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      case (state)
        ARM: if (prime[1] && !in_s) state <= IDLE;
        IDLE: begin
          if (in_s) begin
            state <= MEASURE;
            cnt   <= CNT_W'(1);
          end
        end
        MEASURE: begin
          if (in_s) begin
            if (cnt == MAX_C) begin
              state  <= OVERLONG;
              long_q <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else begin
            state <= IDLE;
            if (cnt < MIN_C) begin
              short_q <= 1'b1;
            end else begin
              evt_q   <= 1'b1;
              width_q <= cnt;
              ecnt_q  <= ecnt_q + 8'd1;
            end
          end
        end
        OVERLONG: if (!in_s) state <= IDLE;
        default: state <= ARM;
      endcase
    end
  end

  assign pw.evt         = evt_q;
  assign pw.width       = width_q;
  assign pw.err_short   = short_q;
  assign pw.err_long    = long_q;
  assign pw.event_count = ecnt_q;
  assign pw.busy        = (state == MEASURE) || (state == OVERLONG);
endmodule

// File: tb/tb_pulse_width_decoder.sv
// Directed bench for pulse_width_decoder: valid, short, long, back-to-back, arm, reset, wrap.
module tb_pulse_width_decoder;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  pulse_width_decoder_if #(.CNT_W(CNT_W)) pw ();

  pulse_width_decoder #(.CNT_W(CNT_W), .MIN_W(2), .MAX_W(200)) dut (
    .clk(clk), .reset_n(reset_n), .pw(pw)
  );

  always #5 clk = ~clk;

  // strobe monitor, sampled mid-cycle
  int n_evt = 0, n_short = 0, n_long = 0, n_multi = 0;
  logic [CNT_W-1:0] last_w = '0, prev_w = '0;
  always @(negedge clk) begin
    if (reset_n) begin
      if (pw.evt) begin
        n_evt++;
        prev_w = last_w;
        last_w = pw.width;
      end
      if (pw.err_short) n_short++;
      if (pw.err_long) n_long++;
      if (int'(pw.evt) + int'(pw.err_short) + int'(pw.err_long) > 1) n_multi++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int n);
    @(negedge clk) pw.in = 1'b1;
    repeat (n) @(negedge clk);
    pw.in = 1'b0;
  endtask

  task automatic do_reset(input logic line);
    @(negedge clk);
    pw.in   = line;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    pw.in = 1'b0;
    reset_n = 1'b0;
    #12;
    checks++;
    if ({pw.evt, pw.width, pw.err_short, pw.err_long, pw.busy, pw.event_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: evt=%b width=%0d es=%b el=%b busy=%b cnt=%0d required all 0",
               pw.evt, pw.width, pw.err_short, pw.err_long, pw.busy, pw.event_count);
    end
    do_reset(1'b0);
    idle(5);
    checks++;
    if (pw.busy !== 1'b0 || pw.event_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_release: busy=%b cnt=%0d required 0 0", pw.busy, pw.event_count);
    end
  endtask

  task automatic test_valid();
    logic [2:0] seen;
    pulse(3);
    for (int e = 0; e < 3; e++) begin
      @(posedge clk); #1;
      seen[e] = pw.evt;
    end
    checks++;
    if (seen !== 3'b100) begin
      errors++;
      $display("FAIL valid_latency: evt after edges 3..1 = %b required 100", seen);
    end
    checks++;
    if (pw.width !== 8'd3 || pw.event_count !== 8'd1) begin
      errors++;
      $display("FAIL valid_width: width=%0d cnt=%0d required 3 1", pw.width, pw.event_count);
    end
    idle(3);
    checks++;
    if (n_evt !== 1 || n_short !== 0 || n_long !== 0) begin
      errors++;
      $display("FAIL valid_strobes: evt=%0d short=%0d long=%0d required 1 0 0", n_evt, n_short, n_long);
    end
  endtask

  task automatic test_short();
    int e0 = n_evt, s0 = n_short;
    pulse(1);
    idle(6);
    checks++;
    if (n_short - s0 !== 1 || n_evt - e0 !== 0) begin
      errors++;
      $display("FAIL short_strobe: short=%0d evt=%0d required 1 0", n_short - s0, n_evt - e0);
    end
    checks++;
    if (pw.width !== 8'd3 || pw.event_count !== 8'd1) begin
      errors++;
      $display("FAIL short_hold: width=%0d cnt=%0d required 3 1", pw.width, pw.event_count);
    end
  endtask

  task automatic test_long();
    int first = 0, nl = 0, e0 = n_evt;
    logic b1, b2;
    @(negedge clk) pw.in = 1'b1;
    for (int e = 1; e <= 250; e++) begin
      @(posedge clk); #1;
      if (pw.err_long) begin
        nl++;
        if (first == 0) first = e;
      end
    end
    checks++;
    if (first !== 203 || nl !== 1) begin
      errors++;
      $display("FAIL long_timing: first edge=%0d count=%0d required 203 1", first, nl);
    end
    checks++;
    if (pw.busy !== 1'b1) begin
      errors++;
      $display("FAIL long_busy_high: busy=%b required 1", pw.busy);
    end
    @(negedge clk) pw.in = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; b1 = pw.busy;
    @(posedge clk); #1; b2 = pw.busy;
    checks++;
    if (b1 !== 1'b1 || b2 !== 1'b0) begin
      errors++;
      $display("FAIL long_busy_fall: busy at edge2=%b edge3=%b required 1 0", b1, b2);
    end
    idle(3);
    checks++;
    if (n_evt - e0 !== 0 || pw.width !== 8'd3 || pw.event_count !== 8'd1) begin
      errors++;
      $display("FAIL long_no_event: evt=%0d width=%0d cnt=%0d required 0 3 1",
               n_evt - e0, pw.width, pw.event_count);
    end
  endtask

  task automatic test_back_to_back();
    int e0;
    do_reset(1'b0);
    idle(5);
    e0 = n_evt;
    pulse(5);
    @(negedge clk) pw.in = 1'b1;
    repeat (5) @(negedge clk);
    pw.in = 1'b0;
    idle(6);
    checks++;
    if (n_evt - e0 !== 2 || prev_w !== 8'd5 || last_w !== 8'd5 || pw.event_count !== 8'd2) begin
      errors++;
      $display("FAIL back_to_back: evt=%0d widths=%0d,%0d cnt=%0d required 2 5,5 2",
               n_evt - e0, prev_w, last_w, pw.event_count);
    end
  endtask

  task automatic test_arm();
    int e0 = n_evt, s0 = n_short, l0 = n_long;
    do_reset(1'b1);
    idle(10);
    checks++;
    if (pw.busy !== 1'b0) begin
      errors++;
      $display("FAIL arm_busy: busy=%b required 0", pw.busy);
    end
    @(negedge clk) pw.in = 1'b0;
    idle(5);
    checks++;
    if (n_evt - e0 !== 0 || n_short - s0 !== 0 || n_long - l0 !== 0) begin
      errors++;
      $display("FAIL arm_ignore: evt=%0d short=%0d long=%0d required 0 0 0",
               n_evt - e0, n_short - s0, n_long - l0);
    end
    pulse(4);
    idle(6);
    checks++;
    if (n_evt - e0 !== 1 || pw.width !== 8'd4 || pw.event_count !== 8'd1) begin
      errors++;
      $display("FAIL arm_second: evt=%0d width=%0d cnt=%0d required 1 4 1",
               n_evt - e0, pw.width, pw.event_count);
    end
  endtask

  task automatic test_reset_mid();
    int e0 = n_evt;
    @(negedge clk) pw.in = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({pw.evt, pw.width, pw.err_short, pw.err_long, pw.busy, pw.event_count} !== '0) begin
      errors++;
      $display("FAIL reset_mid_async: width=%0d busy=%b cnt=%0d required 0 0 0",
               pw.width, pw.busy, pw.event_count);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk) pw.in = 1'b0;
    idle(5);
    checks++;
    if (n_evt - e0 !== 0 || pw.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_noevt: evt=%0d busy=%b required 0 0", n_evt - e0, pw.busy);
    end
    pulse(2);
    idle(6);
    checks++;
    if (n_evt - e0 !== 1 || pw.width !== 8'd2 || pw.event_count !== 8'd1) begin
      errors++;
      $display("FAIL reset_mid_next: evt=%0d width=%0d cnt=%0d required 1 2 1",
               n_evt - e0, pw.width, pw.event_count);
    end
  endtask

  task automatic test_wrap();
    do_reset(1'b0);
    idle(5);
    for (int i = 0; i < 255; i++) begin
      pulse(2);
      @(negedge clk);
    end
    idle(5);
    checks++;
    if (pw.event_count !== 8'd255) begin
      errors++;
      $display("FAIL wrap_255: cnt=%0d required 255", pw.event_count);
    end
    pulse(2);
    idle(6);
    checks++;
    if (pw.event_count !== 8'd0 || pw.width !== 8'd2) begin
      errors++;
      $display("FAIL wrap_0: cnt=%0d width=%0d required 0 2", pw.event_count, pw.width);
    end
    checks++;
    if (n_multi !== 0) begin
      errors++;
      $display("FAIL exclusive: cycles with multiple strobes=%0d required 0", n_multi);
    end
  endtask

  initial begin
    test_reset();
    test_valid();
    test_short();
    test_long();
    test_back_to_back();
    test_arm();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pulse_width_decoder.md
Name: pulse_width_decoder

Overview:
- Receive-side counterpart to the team's one-shot pulse stretcher.
- Samples an asynchronous pulse line and measures each high pulse in clk cycles.
- Rejects glitches that are too short and pulses that are too long.
- Emits a single-cycle event carrying the measured width for downstream control logic.

Parameters:
CNT_W, 8, width of the pulse-width counter and of the width output
MIN_W, 2, minimum accepted high width in cycles; narrower pulses are rejected as glitches
MAX_W, 200, maximum accepted high width in cycles (MIN_W <= MAX_W <= 2^CNT_W-1)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
in  input  1  asynchronous pulse line being decoded
event  output  1  one-cycle strobe: valid pulse decoded
width  output  CNT_W  width of last valid pulse; updated only with event, held otherwise
err_short  output  1  one-cycle strobe: pulse narrower than MIN_W
err_long  output  1  one-cycle strobe: pulse exceeded MAX_W
busy  output  1  high while in MEASURE or OVERLONG
event_count  output  8  count of valid events; wraps 255->0

Behaviour:
- Reset (asynchronous, reset_n low):
  - Outputs: event=0, width=0, err_short=0, err_long=0, busy=0, event_count=0.
  - Internal: sync flops=0, counter=0, state=ARM.
- Synchronizer: 2-flop chain on in produces in_s. in_s lags in by 2 clk edges. All decisions use in_s only.
- States:
  - ARM: wait for in_s==0, then go to IDLE. A line already high at reset release is never counted.
  - IDLE: in_s==1 -> MEASURE, cnt=1.
  - MEASURE, in_s==1:
    - cnt==MAX_W -> OVERLONG, err_long=1 for this one cycle.
    - Otherwise cnt=cnt+1.
  - MEASURE, in_s==0:
    - cnt<MIN_W -> err_short=1 for one cycle, go to IDLE.
    - Otherwise event=1 for one cycle, width=cnt, event_count+1, go to IDLE.
  - OVERLONG: remain until in_s==0, then go to IDLE. No event and no further strobes for that pulse.
- Width definition: cnt equals the number of consecutive clk cycles with in_s==1. The counter never exceeds MAX_W; OVERLONG stops counting.
- Latency:
  - event/err_short asserts in the cycle the FSM sees the first in_s==0 after a pulse, i.e. 3 clk edges after the falling edge of in.
  - err_long asserts on the cycle after the MAX_W-th high sample.
- Strobes:
  - event, err_short and err_long are mutually exclusive.
  - Each is high for exactly one cycle per pulse.
  - busy is combinational from state.
- Back-to-back pulses: a single low sample between pulses is enough. The FSM returns to IDLE on that low cycle, and the next high sample starts a new MEASURE.
- Wrap: event_count rolls 255->0 with no flag.
- Reset mid-pulse: all state clears immediately with no strobe. After release the FSM sits in ARM until in_s is low.

Test Plan:
- Reset, hold in=0, then in high for 3 cycles (matches one-shot output) -> one event pulse, width=3, event_count=1, no error strobes.
- in high for 1 cycle (MIN_W=2) -> err_short for exactly one cycle, no event, event_count and width unchanged.
- in high for 250 cycles (MAX_W=200) -> err_long one cycle after the 200th high sample, busy high until in_s falls, no event, width unchanged.
- Two 5-cycle pulses separated by one low cycle -> two event strobes, width=5 both times, event_count=2.
- Hold in=1 through reset release for 10 cycles, drop it, then apply a 4-cycle pulse -> no strobe for the first pulse; event width=4 for the second.
- Assert reset_n low midway through a 6-cycle pulse -> all outputs 0 asynchronously, no event; after release, next clean 2-cycle pulse -> event, width=2, event_count=1.
- Apply 256 valid pulses -> event_count wraps to 0.
